// File: rtl/out_port_uart_pkg.sv
// Shared types and defaults for the OUT-register UART output stage.
// Imported by the TX core and the top-level wrapper.
package out_port_uart_pkg;

    localparam int REGSIZE    = 8;
    localparam int UART_WTIME = 868;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } TX_STATE_TYPE;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_START = START;
    localparam logic [1:0] ST_DATA  = DATA;
    localparam logic [1:0] ST_STOP  = STOP;

endpackage

// File: rtl/out_port_uart_tx.sv
// 8N1 serialiser: bit timer, shift register and frame FSM.
// Accepts one byte per frame through a valid/ready handshake.
module uart_tx_core
    import out_port_uart_pkg::*;
#(
    parameter int DATA_W = REGSIZE,
    parameter int WTIME  = UART_WTIME
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              tx
);

    localparam int TW = (WTIME > 1) ? $clog2(WTIME) : 1;
    localparam int BW = $clog2(DATA_W);
    localparam logic [TW-1:0] TLAST = TW'(WTIME - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_W - 1);

    logic [1:0]        state;
    logic [TW-1:0]     timer;
    logic [BW-1:0]     bitcnt;
    logic [DATA_W-1:0] shreg;
    logic              tick;

    assign tick  = (timer == TLAST);
    assign ready = (state == ST_IDLE);

    // tx is loaded with the level of the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            timer  <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            tx     <= 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (valid) begin
                        shreg  <= data;
                        bitcnt <= '0;
                        timer  <= '0;
                        state  <= ST_START;
                        tx     <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        timer <= '0;
                        state <= ST_DATA;
                        tx    <= shreg[0];
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        timer <= '0;
                        shreg <= shreg >> 1;
                        if (bitcnt == BLAST) begin
                            state <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                            tx     <= shreg[1];
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        timer <= '0;
                        state <= ST_IDLE;
                        tx    <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/out_port_uart.sv
// Watches the CPU OUT register, queues each new value and sends it
// as an 8N1 UART frame; overflow is flagged, never back-pressured.
module out_port_uart
    import out_port_uart_pkg::*;
#(
    parameter int DATA_W = REGSIZE,
    parameter int WTIME  = UART_WTIME,
    parameter int DEPTH  = FIFO_DEPTH
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    input  logic [DATA_W-1:0]      OUT,
    output logic                   UART_TX,
    output logic                   busy,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              valid;
    logic              ready;

    assign push_req = (OUT != out_q);
    assign valid    = (fifo_count != '0);
    assign pop      = valid & ready;
    // a pop on the same edge frees the slot the push needs
    assign push     = push_req & ((fifo_count < CW'(DEPTH)) | pop);
    assign busy     = ~ready | valid;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            out_q      <= '0;
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            out_q <= OUT;
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            if (push_req & ~push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (push) begin
            mem[wptr] <= OUT;
        end
    end

    uart_tx_core #(
        .DATA_W (DATA_W),
        .WTIME  (WTIME)
    ) u_tx (
        .clk   (CLOCK),
        .rst_n (RESET),
        .valid (valid),
        .data  (mem[rptr]),
        .ready (ready),
        .tx    (UART_TX)
    );

endmodule

// File: tb/tb_out_port_uart.sv
// Scoreboard bench: stimulus queues expected bytes, a UART
// receiver monitor decodes frames and compares them.
module tb_out_port_uart;

    localparam int WT = 4;
    localparam int DP = 4;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic [7:0] OUT;
    logic       UART_TX;
    logic       busy;
    logic       overflow;
    logic [2:0] fifo_count;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         frames = 0;
    int         peak = 0;
    bit         rx_active = 1'b0;
    logic [7:0] exp_q[$];
    int         starts[$];

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) cyc <= cyc + 1;

    out_port_uart #(
        .DATA_W (8),
        .WTIME  (WT),
        .DEPTH  (DP)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .OUT        (OUT),
        .UART_TX    (UART_TX),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // UART receiver: samples every negedge, 4 samples per bit
    initial begin : monitor
        int         nsamp;
        int         idx;
        logic [9:0] bits;
        bit         wok;
        logic [7:0] got;
        logic [7:0] e;
        forever begin
            @(negedge CLOCK);
            if (RESET !== 1'b1) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (UART_TX === 1'b0) begin
                    rx_active = 1'b1;
                    nsamp = 1;
                    bits = '1;
                    bits[0] = 1'b0;
                    wok = 1'b1;
                    starts.push_back(cyc);
                end
            end else begin
                idx = nsamp / WT;
                if (nsamp % WT == 0) begin
                    bits[idx] = UART_TX;
                end else if (bits[idx] !== UART_TX) begin
                    wok = 1'b0;
                end
                nsamp++;
                if (nsamp == 10 * WT) begin
                    rx_active = 1'b0;
                    got = bits[8:1];
                    frames++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame: got %h expected none", got);
                    end else begin
                        e = exp_q.pop_front();
                        if (!wok || bits[0] !== 1'b0 || bits[9] !== 1'b1 ||
                            got !== e) begin
                            errors++;
                            $display("FAIL frame: got %h bits %b width_ok %0d expected %h",
                                     got, bits, wok, e);
                        end
                    end
                end
            end
        end
    end

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        do begin
            @(negedge CLOCK);
            n++;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end while ((busy || rx_active) && n < limit);
        check({name, " timeout"}, int'(busy | rx_active), 0);
        check({name, " pending"}, exp_q.size(), 0);
    endtask

    initial begin : stim
        int c0;
        int f0;
        int bz;
        int lat;
        RESET = 1'b0;
        OUT = 8'h00;
        repeat (3) @(negedge CLOCK);
        RESET = 1'b1;
        repeat (5) @(negedge CLOCK);

        // reset asserted mid-cycle acts at once
        @(posedge CLOCK);
        #2 RESET = 1'b0;
        #1;
        check("rst tx", int'(UART_TX), 1);
        check("rst busy", int'(busy), 0);
        check("rst overflow", int'(overflow), 0);
        check("rst count", int'(fifo_count), 0);
        @(negedge CLOCK);
        RESET = 1'b1;
        bz = 0;
        repeat (100) begin
            @(negedge CLOCK);
            if (busy || UART_TX !== 1'b1) bz++;
        end
        check("idle activity", bz, 0);
        check("idle frames", frames, 0);

        // single byte with exact latency and busy fall
        @(negedge CLOCK);
        starts.delete();
        OUT = 8'h67;
        c0 = cyc;
        exp_q.push_back(8'h67);
        while (cyc < c0 + 41) @(negedge CLOCK);
        check("busy in stop", int'(busy), 1);
        @(negedge CLOCK);
        check("busy after stop", int'(busy), 0);
        lat = (starts.size() > 0) ? starts[0] - c0 : -1;
        check("start latency", lat, 2);
        drain("single", 100);

        // same value held and rewritten sends once
        f0 = frames;
        @(negedge CLOCK);
        OUT = 8'h5A;
        exp_q.push_back(8'h5A);
        repeat (200) @(negedge CLOCK);
        OUT = 8'h5A;
        repeat (60) @(negedge CLOCK);
        check("repeat frames", frames - f0, 1);
        drain("repeat", 100);

        // burst absorbed by the FIFO
        starts.delete();
        peak = 0;
        f0 = frames;
        for (int v = 1; v <= 5; v++) begin
            @(negedge CLOCK);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            OUT = 8'(v);
            exp_q.push_back(8'(v));
        end
        drain("burst", 400);
        check("burst peak", peak, 4);
        check("burst overflow", int'(overflow), 0);
        check("burst frames", frames - f0, 5);
        check("burst starts", starts.size(), 5);
        for (int i = 1; i < starts.size(); i++) begin
            check("burst pitch", starts[i] - starts[i-1], 41);
        end

        // two of seven pushes dropped
        f0 = frames;
        for (int v = 1; v <= 7; v++) begin
            @(negedge CLOCK);
            OUT = 8'(v * 17);
            if (v <= 5) exp_q.push_back(8'(v * 17));
        end
        drain("overflow", 500);
        check("ovf flag", int'(overflow), 1);
        check("ovf frames", frames - f0, 5);
        check("ovf count", int'(fifo_count), 0);
        repeat (20) @(negedge CLOCK);
        check("ovf sticky", int'(overflow), 1);

        // reset during data bit 3 of A5
        @(negedge CLOCK);
        OUT = 8'hA5;
        c0 = cyc;
        while (cyc < c0 + 19) @(negedge CLOCK);
        check("pre-reset bit3", int'(UART_TX), 0);
        #2 RESET = 1'b0;
        OUT = 8'h00;
        #1;
        check("midrst tx", int'(UART_TX), 1);
        check("midrst count", int'(fifo_count), 0);
        check("midrst busy", int'(busy), 0);
        check("midrst overflow", int'(overflow), 0);
        repeat (3) @(negedge CLOCK);
        RESET = 1'b1;
        repeat (5) @(negedge CLOCK);
        f0 = frames;
        OUT = 8'h3C;
        exp_q.push_back(8'h3C);
        drain("post-reset", 100);
        check("post-reset frames", frames - f0, 1);

        check("final queue", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        errors++;
        $display("FAIL watchdog: got no finish expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
